// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the burst FIFO controller.
package fifo_ctrl_pkg;

  localparam int DEF_RSA_DW = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int STATS_W    = 16;

  // Read-burst sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } burst_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester above the
// last winner (with wrap-around). The pointer only moves on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic [REQ_W-1:0] ptr_q;
  logic [REQ_W-1:0] ptr_d;
  logic [REQ_W-1:0] win_idx;
  logic [REQ_W-1:0] cand;
  logic             found;

  // Search upward from ptr+1, first hit wins
  always_comb begin
    grant   = '0;
    win_idx = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = REQ_W'((int'(ptr_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = cand;
      end
    end
    ptr_d = advance ? win_idx : ptr_q;
  end

  // Pointer register; starts at the top so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Burst controller in front of a sync FIFO: round-robin write arbitration
// among NUM_REQ producers, own occupancy tracking, and read-burst
// sequencing towards the RSA consumer.
// Optional: define FIFO_CTRL_STATS_EN to add the stall_cnt output.
module fifo_burst_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int RSA_DW     = DEF_RSA_DW,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REQ    = 4,
  parameter int REQ_W      = 2
) (
  input  logic                       clk,
  input  logic                       sys_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*RSA_DW-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_wr_en,
  output logic [RSA_DW-1:0]          fifo_wr_data,
  output logic                       fifo_rd_en,
  input  logic [RSA_DW-1:0]          fifo_data_out,
  input  logic                       burst_start,
  input  logic [ADDR_WIDTH:0]        burst_len,
  output logic                       burst_busy,
  output logic                       burst_err,
  output logic                       out_valid,
  output logic [RSA_DW-1:0]          out_data,
  output logic                       out_last,
`ifdef FIFO_CTRL_STATS_EN
  output logic [STATS_W-1:0]         stall_cnt,
`endif
  output logic [ADDR_WIDTH:0]        level
);

  localparam int            LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // ---------------- write arbitration ----------------
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               full;
  logic [RSA_DW-1:0]  win_data;

  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      avail;
  logic               wr_en_q, wr_en_d;
  logic [RSA_DW-1:0]  wr_data_q, wr_data_d;

  // A read in the same cycle does not free a slot: fullness uses level_q only
  assign full    = (level_q == DEPTH_L);
  assign arb_req = full ? '0 : req_valid;
  assign accept  = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = grant;

  // Select the granted requester's word (grant is one-hot)
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_data = win_data | req_data[i*RSA_DW +: RSA_DW];
      end
    end
  end

  // ---------------- burst FSM signals ----------------
  burst_state_e   state_q, state_d;
  logic [LW-1:0]  rem_q, rem_d;
  logic           rd_en_q, rd_en_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           len_ok;

  // Write strobe/data one cycle after acceptance; occupancy bookkeeping
  always_comb begin
    wr_en_d   = accept;
    wr_data_d = accept ? win_data : wr_data_q;
    case ({accept, rd_en_q})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Write path and level registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      level_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      level_q   <= level_d;
    end
  end

  // Words physically in the FIFO: the in-flight write is not readable yet
  assign avail  = level_q - LW'(wr_en_q);
  assign len_ok = (burst_len != '0) && (burst_len <= DEPTH_L);

  // Next-state logic for the read-burst sequencer
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    rd_en_d     = 1'b0;
    err_d       = 1'b0;
    out_last_d  = 1'b0;
    out_valid_d = rd_en_q;
    case (state_q)
      IDLE: begin
        if (burst_start) begin
          if (len_ok) begin
            rem_d   = burst_len;
            state_d = WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (avail >= rem_q) begin
          state_d = BURST;
          rd_en_d = 1'b1;
        end
      end
      BURST: begin
        rem_d = rem_q - LW'(1);
        if (rem_q == LW'(1)) begin
          state_d    = DRAIN;
          out_last_d = 1'b1;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and its registered outputs
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign fifo_rd_en   = rd_en_q;
  assign burst_busy   = busy_q;
  assign burst_err    = err_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_data     = out_valid_q ? fifo_data_out : '0;
  assign level        = level_q;

`ifdef FIFO_CTRL_STATS_EN
  logic [STATS_W-1:0] stall_q, stall_d;

  // Count cycles with pending requests but no acceptance, saturating
  always_comb begin
    stall_d = stall_q;
    if ((|req_valid) && !accept && (stall_q != {STATS_W{1'b1}})) begin
      stall_d = stall_q + STATS_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed testbench for fifo_burst_ctrl with a behavioural sync FIFO.
module tb_fifo_burst_ctrl;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int NR = 4;
  localparam int RW = 2;

  logic             clk = 1'b0;
  logic             sys_rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_data_out;
  logic             burst_start;
  logic [AW:0]      burst_len;
  logic             burst_busy;
  logic             burst_err;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [AW:0]      level;
`ifdef FIFO_CTRL_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] got_data [16];
  logic          got_last [16];
  int            got_n;

  always #5 clk = ~clk;

  fifo_burst_ctrl #(
    .RSA_DW(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_REQ(NR), .REQ_W(RW)
  ) dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .burst_start   (burst_start),
    .burst_len     (burst_len),
    .burst_busy    (burst_busy),
    .burst_err     (burst_err),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
`ifdef FIFO_CTRL_STATS_EN
    .stall_cnt     (stall_cnt),
`endif
    .level         (level)
  );

  // Behavioural sync FIFO: registered read data, shares the reset
  logic [DW-1:0] fmem [DEPTH];
  logic [AW-1:0] fwp, frp;
  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fwp <= '0;
      frp <= '0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_wr_en) begin
        fmem[fwp] <= fifo_wr_data;
        fwp <= fwp + 1'b1;
      end
      if (fifo_rd_en) begin
        fifo_data_out <= fmem[frp];
        frp <= frp + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    burst_start = 1'b0;
    burst_len = '0;
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic write_words(input int r, input logic [DW-1:0] d0, input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_data[r*DW +: DW] = DW'(d0 + DW'(k));
      tick();
    end
    req_valid = '0;
  endtask

  task automatic collect(input int max_cycles);
    got_n = 0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      if (out_valid) begin
        if (got_n < 16) begin
          got_data[got_n] = out_data;
          got_last[got_n] = out_last;
        end
        $display("out word %0d data=%02h last=%0b", got_n, out_data, out_last);
        got_n++;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    burst_start = 1'b0;
    burst_len = '0;
    #3;
    n_cmp++;
    if ({req_ready, fifo_wr_en, fifo_rd_en, burst_busy, burst_err, out_valid, out_data, out_last, level} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b rd=%b busy=%b err=%b ov=%b od=%h ol=%b lvl=%0d, want all 0",
               req_ready, fifo_wr_en, fifo_rd_en, burst_busy, burst_err, out_valid, out_data, out_last, level);
    end
    repeat (2) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({burst_busy, level, fifo_rd_en} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%b lvl=%0d rd=%b, want 0/0/0", burst_busy, level, fifo_rd_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      req_data[7:0] = 8'(8'h11 + k);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
        n_bad++;
        $display("FAIL single_ready: got %b want 0001", req_ready);
      end
      tick();
      $display("accept req0 data=%02h", 8'(8'h11 + k));
      n_cmp++;
      if ({fifo_wr_en, fifo_wr_data} !== {1'b1, 8'(8'h11 + k)}) begin
        n_bad++;
        $display("FAIL single_write: got en=%b data=%02h want en=1 data=%02h", fifo_wr_en, fifo_wr_data, 8'(8'h11 + k));
      end
      n_cmp++;
      if (level !== 4'(k + 1)) begin
        n_bad++;
        $display("FAIL single_level: got %0d want %0d", level, k + 1);
      end
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if (fifo_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL single_wr_idle: got %b want 0", fifo_wr_en);
    end
    burst_start = 1'b1;
    burst_len = 4'd3;
    tick();
    burst_start = 1'b0;
    n_cmp++;
    if ({burst_busy, fifo_rd_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_wait: got busy=%b rd=%b want busy=1 rd=0", burst_busy, fifo_rd_en);
    end
    collect(8);
    n_cmp++;
    if (got_n !== 3) begin
      n_bad++;
      $display("FAIL single_count: got %0d words want 3", got_n);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {8'(8'h11 + i), (i == 2)}) begin
        n_bad++;
        $display("FAIL single_word%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i], 8'(8'h11 + i), (i == 2));
      end
    end
    n_cmp++;
    if ({level, burst_busy} !== 5'd0) begin
      n_bad++;
      $display("FAIL single_end: got lvl=%0d busy=%b want 0/0", level, burst_busy);
    end
  endtask

  task automatic test_rr_full();
    do_reset();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'(8'hA0 + i);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
      $display("accept req%0d data=%02h", k % 4, fifo_wr_data);
      n_cmp++;
      if (fifo_wr_data !== 8'(8'hA0 + k % 4)) begin
        n_bad++;
        $display("FAIL rr_data%0d: got %02h want %02h", k, fifo_wr_data, 8'(8'hA0 + k % 4));
      end
    end
    #1;
    n_cmp++;
    if ({req_ready, level} !== {4'b0000, 4'd8}) begin
      n_bad++;
      $display("FAIL rr_full: got rdy=%b lvl=%0d want 0000/8", req_ready, level);
    end
    tick();
    n_cmp++;
    if ({fifo_wr_en, level} !== {1'b0, 4'd8}) begin
      n_bad++;
      $display("FAIL rr_full_hold: got wr=%b lvl=%0d want 0/8", fifo_wr_en, level);
    end
    // burst of 2 while requesters keep pushing
    burst_start = 1'b1;
    burst_len = 4'd2;
    tick();
    burst_start = 1'b0;
    tick();
    n_cmp++;
    if ({fifo_rd_en, level, req_ready} !== {1'b1, 4'd8, 4'b0000}) begin
      n_bad++;
      $display("FAIL conc_first_read: got rd=%b lvl=%0d rdy=%b want 1/8/0000", fifo_rd_en, level, req_ready);
    end
    tick();
    n_cmp++;
    if ({level, req_ready, out_valid, out_data} !== {4'd7, 4'b0001, 1'b1, 8'hA0}) begin
      n_bad++;
      $display("FAIL conc_after_read: got lvl=%0d rdy=%b ov=%b od=%02h want 7/0001/1/a0", level, req_ready, out_valid, out_data);
    end
    tick();
    n_cmp++;
    if ({level, fifo_wr_en, out_data, out_last} !== {4'd7, 1'b1, 8'hA1, 1'b1}) begin
      n_bad++;
      $display("FAIL conc_coincide: got lvl=%0d wr=%b od=%02h last=%b want 7/1/a1/1", level, fifo_wr_en, out_data, out_last);
    end
    tick();
    n_cmp++;
    if ({level, req_ready} !== {4'd8, 4'b0000}) begin
      n_bad++;
      $display("FAIL conc_refull: got lvl=%0d rdy=%b want 8/0000", level, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wait();
    do_reset();
    write_words(1, 8'h21, 2);
    tick();
    burst_start = 1'b1;
    burst_len = 4'd5;
    tick();
    burst_start = 1'b0;
    n_cmp++;
    if (burst_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_busy: got %b want 1", burst_busy);
    end
    // a start while busy must be ignored, even with an illegal length
    burst_start = 1'b1;
    burst_len = 4'd0;
    tick();
    burst_start = 1'b0;
    n_cmp++;
    if (burst_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_ignore_start: got err=%b want 0", burst_err);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_hold%0d: got rd=%b want 0", c, fifo_rd_en);
      end
    end
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0010;
      req_data[15:8] = 8'(8'h23 + k);
      tick();
      $display("accept req1 data=%02h", 8'(8'h23 + k));
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_fill%0d: got rd=%b want 0", k, fifo_rd_en);
      end
    end
    req_valid = '0;
    tick();
    n_cmp++;
    if ({fifo_rd_en, level} !== {1'b0, 4'd5}) begin
      n_bad++;
      $display("FAIL wait_inflight: got rd=%b lvl=%0d want 0/5", fifo_rd_en, level);
    end
    tick();
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_release: got rd=%b want 1", fifo_rd_en);
    end
    collect(10);
    n_cmp++;
    if (got_n !== 5) begin
      n_bad++;
      $display("FAIL wait_count: got %0d words want 5", got_n);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({got_data[i], got_last[i]} !== {8'(8'h21 + i), (i == 4)}) begin
        n_bad++;
        $display("FAIL wait_word%0d: got %02h/%b want %02h/%b", i, got_data[i], got_last[i], 8'(8'h21 + i), (i == 4));
      end
    end
  endtask

  task automatic test_err();
    logic [AW:0] bad_len [2];
    bad_len[0] = 4'd0;
    bad_len[1] = 4'd9;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      burst_len = bad_len[i];
      burst_start = 1'b1;
      tick();
      burst_start = 1'b0;
      $display("burst_start len=%0d err=%b busy=%b", bad_len[i], burst_err, burst_busy);
      n_cmp++;
      if ({burst_err, burst_busy} !== 2'b10) begin
        n_bad++;
        $display("FAIL err_pulse_len%0d: got err=%b busy=%b want 1/0", bad_len[i], burst_err, burst_busy);
      end
      tick();
      n_cmp++;
      if ({burst_err, burst_busy, fifo_rd_en} !== 3'b000) begin
        n_bad++;
        $display("FAIL err_after_len%0d: got err=%b busy=%b rd=%b want 0/0/0", bad_len[i], burst_err, burst_busy, fifo_rd_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_words(0, 8'h31, 3);
    tick();
    burst_start = 1'b1;
    burst_len = 4'd3;
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, out_data, burst_busy, burst_err, fifo_rd_en, fifo_wr_en, level, req_ready} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got ov=%b ol=%b od=%02h busy=%b rd=%b wr=%b lvl=%0d want all 0",
               out_valid, out_last, out_data, burst_busy, fifo_rd_en, fifo_wr_en, level);
    end
    @(negedge clk);
    sys_rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({burst_busy, out_valid, out_last} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_idle: got busy=%b ov=%b ol=%b want 0/0/0", burst_busy, out_valid, out_last);
    end
    write_words(2, 8'hAA, 1);
    tick();
    burst_start = 1'b1;
    burst_len = 4'd1;
    tick();
    burst_start = 1'b0;
    collect(8);
    n_cmp++;
    if (got_n !== 1) begin
      n_bad++;
      $display("FAIL midreset_count: got %0d words want 1", got_n);
    end
    n_cmp++;
    if ({got_data[0], got_last[0]} !== {8'hAA, 1'b1}) begin
      n_bad++;
      $display("FAIL midreset_word: got %02h/%b want aa/1", got_data[0], got_last[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_full();
    test_wait();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
